// File: rtl/calc_pkg.sv
// Shared constants for the calculator display path: status codes, special
// glyphs and the scan-state encoding.
package calc_pkg;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_IDLE  = 2'b11;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic {DEAD, SHOW} scan_st_t;

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low seven-segment glyph, segment order {g,f,e,d,c,b,a}.
module seg7_decode (
  input  logic [3:0] val,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (val)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/calc_display.sv
// Eight-digit multiplexed seven-segment display controller with digit buffer.
// Optional error banner ("Err") while status is error: CALC_DISPLAY_ERR_MSG_EN.
module calc_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] pos,
  input  logic [3:0] dig,
  input  logic       clr,
  input  logic [1:0] status,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam scan_st_t RST_ST = (DEAD_CYCLES > 0) ? DEAD : SHOW;

  logic [7:0][3:0] digit;
  logic [7:0]      valid;
  logic [CW-1:0]   slot_cnt, slot_nxt;
  logic [2:0]      idx;
  logic            dp_tgl, wrap;
  scan_st_t        st, st_nxt;
  logic [6:0]      glyph, seg_d;
  logic [7:0]      an_d;
  logic            dp_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit <= '0;
      valid <= '0;
    end else if (clr) begin
      digit <= '0;
      valid <= '0;
    end else if (wr_en && !pos[3]) begin
      digit[pos[2:0]] <= dig;
      valid[pos[2:0]] <= 1'b1;
    end
  end

  assign wrap     = (slot_cnt == CW'(REFRESH_DIV - 1));
  assign slot_nxt = wrap ? '0 : slot_cnt + 1'b1;

  // dp_tgl flips once per frame, at the slot-7 to slot-0 wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= '0;
      dp_tgl   <= 1'b0;
    end else begin
      slot_cnt <= slot_nxt;
      if (wrap) idx <= idx + 3'd1;
      if (wrap && idx == 3'd7) dp_tgl <= ~dp_tgl;
    end
  end

  // State tracks slot_cnt: it is registered from the next counter value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) st <= RST_ST;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = (int'(slot_nxt) < DEAD_CYCLES) ? DEAD : SHOW;
  end

  seg7_decode u_dec (.val(digit[idx]), .seg(glyph));

  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (st == SHOW) begin
      an_d  = ~(8'd1 << idx);
      seg_d = valid[idx] ? glyph : SEG_BLANK;
`ifdef CALC_DISPLAY_ERR_MSG_EN
      if (status == ST_ERR) begin
        case (idx)
          3'd2:       seg_d = SEG_E;
          3'd1, 3'd0: seg_d = SEG_R;
          default:    seg_d = SEG_BLANK;
        endcase
      end
`endif
      if (idx == 3'd7) begin
        if (status == ST_READY)     dp_d = 1'b0;
        else if (status == ST_BUSY) dp_d = dp_tgl;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_calc_display.sv
// Scoreboarded bench for calc_display with REFRESH_DIV=8, DEAD_CYCLES=2.
module tb_calc_display;

  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FR = 8 * RD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] pos   = '0;
  logic [3:0] dig   = '0;
  logic       clr   = 1'b0;
  logic [1:0] status = 2'b11;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  calc_display #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .pos(pos), .dig(dig),
    .clr(clr), .status(status), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [15:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
               nm, act[15:8], act[7:1], act[0], exp_v[15:8], exp_v[7:1], exp_v[0]);
    end
  endtask

  // Expectation tagged with cyc = posedges since reset release; at that cycle's
  // negedge the outputs reflect scan state t = cyc-1.
  always @(negedge clock) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        if (mon_e.cyc < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s: check missed at cycle %0d, required cycle %0d", mon_e.nm, cyc, mon_e.cyc);
        end else begin
          cmp(mon_e.nm, {an, seg, dp}, mon_e.v);
        end
      end
    end
  end

  // Frame f, slot k: one DEAD-phase check and one SHOW-phase check.
  task automatic push_frame(input int f, input logic [7:0][6:0] s, input logic dp7);
    exp_t e;
    logic [7:0] a;
    for (int k = 0; k < 8; k++) begin
      e.cyc = f * FR + k * RD + 1;
      e.v   = {8'hFF, 7'h7F, 1'b1};
      e.nm  = $sformatf("f%0d_s%0d_dead", f, k);
      sb.push_back(e);
      a    = 8'hFF;
      a[k] = 1'b0;
      e.cyc = f * FR + k * RD + DC + 1;
      e.v   = {a, s[k], (k == 7) ? dp7 : 1'b1};
      e.nm  = $sformatf("f%0d_s%0d_show", f, k);
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [3:0] p, input logic [3:0] d, input logic c);
    wr_en = 1'b1; pos = p; dig = d; clr = c;
    @(posedge clock); #1;
    wr_en = 1'b0; clr = 1'b0;
  endtask

  logic [7:0][6:0] fs;

  initial begin
    #10000000;
    $display("FAIL timeout: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    #23;
    cmp("reset_outputs", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
    fs = {8{7'h7F}};
    push_frame(0, fs, 1'b1);
    push_frame(1, fs, 1'b1);
    @(negedge clock) reset = 1'b0;

    // Digit 7 at slot 0, A at slot 3.
    wait_cyc(2 * FR);
    do_write(4'd0, 4'h7, 1'b0);
    do_write(4'd3, 4'hA, 1'b0);
    fs = {8{7'h7F}};
    fs[0] = 7'b1111000;
    fs[3] = 7'b0001000;
    push_frame(3, fs, 1'b1);

    // Out-of-range position must not alias onto slot 1.
    wait_cyc(4 * FR);
    do_write(4'd9, 4'h5, 1'b0);
    push_frame(5, fs, 1'b1);

    // Clear with a simultaneous write: clear wins.
    wait_cyc(6 * FR);
    do_write(4'd1, 4'h4, 1'b1);
    fs = {8{7'h7F}};
    push_frame(7, fs, 1'b1);

    wait_cyc(8 * FR);
    status = 2'b10;
    push_frame(9, fs, 1'b0);

    // Busy: slot-7 dp follows the per-frame toggle (odd frames off, even lit).
    wait_cyc(10 * FR);
    status = 2'b01;
    push_frame(11, fs, 1'b1);
    push_frame(12, fs, 1'b0);

    wait_cyc(13 * FR);
    status = 2'b00;
    do_write(4'd0, 4'h1, 1'b0);
    do_write(4'd1, 4'h2, 1'b0);
    do_write(4'd2, 4'h3, 1'b0);
    fs = {8{7'h7F}};
`ifdef CALC_DISPLAY_ERR_MSG_EN
    fs[2] = 7'b0000110;
    fs[1] = 7'b0101111;
    fs[0] = 7'b0101111;
`else
    fs[0] = 7'b1111001;
    fs[1] = 7'b0100100;
    fs[2] = 7'b0110000;
`endif
    push_frame(14, fs, 1'b1);

    wait_cyc(15 * FR);
    status = 2'b11;
    fs = {8{7'h7F}};
    fs[0] = 7'b1111001;
    fs[1] = 7'b0100100;
    fs[2] = 7'b0110000;
    push_frame(16, fs, 1'b1);

    // Mid-SHOW of slot 1 in frame 17, then asynchronous reset.
    wait_cyc(17 * FR + RD + 4);
    cmp("pre_reset_show", {an, seg, dp}, {8'hFD, 7'b0100100, 1'b1});
    reset = 1'b1;
    #1;
    cmp("async_reset", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
    @(negedge clock) reset = 1'b0;
    fs = {8{7'h7F}};
    push_frame(0, fs, 1'b1);
    wait_cyc(FR + 4);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_display.md
# calc_display

Display controller downstream of the calculator core. It captures digit writes (`pos`, `dig`) into an 8-entry digit buffer and time-multiplexes the buffer onto eight common-anode seven-segment displays. Anode and segment outputs are registered. The calculator `status` code drives the decimal-point indicator and an optional error message.

## Interface

**Parameters**

- `REFRESH_DIV`, default 100000: clock cycles per display slot; legal range ≥ 4.
- `DEAD_CYCLES`, default 16: cycles at the start of each slot with all anodes off (anti-ghosting). Must be < `REFRESH_DIV`.

**Ports**

- `clock` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `wr_en` in 1: write strobe, one cycle per digit write.
- `pos` in 4: target display index; values 8–15 are ignored.
- `dig` in 4: digit value 0–15 (hex glyph).
- `clr` in 1: clear the whole buffer.
- `status` in 2: calculator status (00 error, 01 busy, 10 ready, 11 idle).
- `an` out 8: anode enables, active-low; `an[i]` is display i.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.

## Operation

**Buffer**
- `digit[0:7]` (4 bits each) plus `valid[0:7]`.
- On `wr_en` with `pos` < 8: `digit[pos]` <= `dig`, `valid[pos]` <= 1.
- On `clr`: all `valid` <= 0 and all `digit` <= 0.
- `clr` and `wr_en` in the same cycle: `clr` wins and the write is dropped.
- Writes with `pos` ≥ 8 are discarded with no side effects.

**Scan**
- `slot_cnt` counts 0..`REFRESH_DIV`-1 and wraps.
- On wrap, `idx` (3 bits) increments modulo 8.
- Scan states:
  - DEAD while `slot_cnt` < `DEAD_CYCLES`.
  - SHOW otherwise.
- DEAD: `an` = 8'hFF and `seg` = 7'h7F.
- SHOW: `an` = ~(1<<`idx`).
  - `seg` = glyph(`digit[idx]`) if `valid[idx]`, else 7'h7F (blank).

**Glyphs**
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

**Decimal point**
- During SHOW with `idx` = 7: `dp` = 0 when `status` = 10 (ready).
- `status` = 01 (busy): `dp` toggles on each `idx` wrap (7→0).
- Otherwise `dp` = 1.

**Reset**
- Outputs: `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1.
- Internal: buffer cleared, `idx` = 0, `slot_cnt` = 0, dp toggle = 0.
- Reset mid-scan or mid-write aborts immediately, asynchronously.

## Timing

- A write becomes visible in the buffer the cycle after the `wr_en` edge.
- Outputs are registered: `an`/`seg`/`dp` reflect the `idx`/`slot_cnt`/buffer state of the previous cycle (1-cycle latency).
- A write to the currently shown slot updates `seg` 2 cycles after the `wr_en` edge.
- Full frame = 8 × `REFRESH_DIV` cycles. Each digit is lit for `REFRESH_DIV` − `DEAD_CYCLES` cycles per frame.
- `status` is sampled every cycle; there is no handshake and no backpressure, so writes are always accepted.

## Configuration

- Macro: `CALC_DISPLAY_ERR_MSG_EN`.
- Defined: while `status` = 00, the buffer is overridden on output (not modified):
  - display 2 = E (0000110), displays 1 and 0 = r (0101111), all others blank.
  - The override lasts as long as `status` = 00.
  - The buffer contents reappear when `status` leaves 00.
- Undefined: `status` = 00 has no effect on `seg`, and `dp` = 1.

## Structure

- Shared package `calc_pkg`:
  - status code constants (`ST_ERR`, `ST_BUSY`, `ST_READY`, `ST_IDLE`);
  - `SEG_BLANK` and the glyph constants for E and r;
  - the scan-state enum {DEAD, SHOW}.
- One combinational sub-module `seg7_decode` (4-bit value → 7-bit active-low glyph), instantiated once on the selected digit.

## Test plan

- Reset, hold 2 frames (`REFRESH_DIV`=8, `DEAD_CYCLES`=2) → `an` cycles 11111110…01111111 in SHOW, 8'hFF in DEAD, `seg` = 7'h7F throughout.
- Write `pos`=0 `dig`=7, `pos`=3 `dig`=0xA → slot 0 `seg` = 1111000, slot 3 `seg` = 0001000, other slots blank.
- Write `pos`=9 `dig`=5, then `clr` with simultaneous write `pos`=1 → buffer unchanged by `pos`=9; all slots blank after `clr`.
- `status`=10 → `dp` = 0 only in slot 7 SHOW. `status`=01 → slot-7 `dp` alternates between consecutive frames.
- With `CALC_DISPLAY_ERR_MSG_EN`, buffer holds 1,2,3 and `status`=00 → slots 2/1/0 show E/r/r. `status`=11 → slots show 3/2/1 again.
- Assert `reset` mid-SHOW → `an` = 8'hFF and `seg` = 7'h7F the same cycle. After release, scan restarts at `idx` 0 with an empty buffer.
